// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU with a multicycle shift-add multiplier and a
// restoring divider sharing one IDLE/RUN/DONE sequencer and the HI/LO pair.
// Optional feature macro: ALU_MDU_DIV_EN. When it is defined, DIV/DIVU run
// on the divider. When it is undefined, DIV/DIVU decode as illegal
// single-cycle ops and no divider is built.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             cout,
    output logic             uov,
    output logic             sov,
    output logic             dz,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADD  = 6'h20, F_SUB  = 6'h22, F_AND  = 6'h24, F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     bmag_q, bmag_d;   // multiplicand / divisor magnitude
    logic                 negp_q, negp_d;   // negate product / quotient at the end
`ifdef ALU_MDU_DIV_EN
    logic                 div_q, div_d;
    logic                 negr_q, negr_d;   // remainder takes the dividend's sign
    logic                 dzp_q, dzp_d;
    logic                 ovp_q, ovp_d;
`endif
    logic [WIDTH-1:0]     res_q, res_d, hi_q, hi_d, lo_q, lo_d;
    logic                 zero_q, zero_d, cout_q, cout_d, uov_q, uov_d, sov_q, sov_d;
    logic                 dz_q, dz_d, done_q, done_d, illegal_q, illegal_d;

    // decode and single-cycle results
    logic                 is_sub, is_mc, is_divop, signed_op, a_neg, b_neg, ovf;
    logic [WIDTH-1:0]     sc_b, a_mag, b_mag, sc_res;
    logic [WIDTH:0]       sum;
    logic                 sc_cout, sc_uov, sc_sov, sc_ill, sc_wh, sc_wl;

    // multicycle datapath
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   step, prod;
    logic [WIDTH-1:0]     fin_hi, fin_lo;
    logic                 fin_sov, fin_dz;
`ifdef ALU_MDU_DIV_EN
    logic [WIDTH:0]       div_r, div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo, rem;
`endif

    // Decode, operand magnitudes and the one-cycle ALU result.
    always_comb begin
`ifdef ALU_MDU_DIV_EN
        is_divop = (func == F_DIV) || (func == F_DIVU);
`else
        is_divop = 1'b0;
`endif
        is_mc     = (func == F_MULT) || (func == F_MULTU) || is_divop;
        signed_op = (func == F_MULT) || (func == F_DIV);
        a_neg     = signed_op & opa[WIDTH-1];
        b_neg     = signed_op & opb[WIDTH-1];
        a_mag     = a_neg ? (~opa + 1'b1) : opa;
        b_mag     = b_neg ? (~opb + 1'b1) : opb;

        is_sub = (func == F_SUB) || (func == F_SLT) || (func == F_SLTU);
        sc_b   = is_sub ? ~opb : opb;
        sum    = {1'b0, opa} + {1'b0, sc_b} + {{WIDTH{1'b0}}, is_sub};
        ovf    = (opa[WIDTH-1] == sc_b[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);

        sc_res  = '0;
        sc_cout = 1'b0;
        sc_uov  = 1'b0;
        sc_sov  = 1'b0;
        sc_ill  = 1'b0;
        sc_wh   = 1'b0;
        sc_wl   = 1'b0;
        case (func)
            F_SLL:  sc_res = opb << opa[SHW-1:0];
            F_SRL:  sc_res = opb >> opa[SHW-1:0];
            F_SRA:  sc_res = $unsigned($signed(opb) >>> opa[SHW-1:0]);
            F_MFHI: sc_res = hi_q;
            F_MFLO: sc_res = lo_q;
            F_MTHI: begin sc_res = opa; sc_wh = 1'b1; end
            F_MTLO: begin sc_res = opa; sc_wl = 1'b1; end
            F_ADD:  begin
                sc_res = sum[WIDTH-1:0]; sc_cout = sum[WIDTH]; sc_uov = sum[WIDTH]; sc_sov = ovf;
            end
            F_SUB:  begin
                sc_res = sum[WIDTH-1:0]; sc_cout = sum[WIDTH]; sc_uov = ~sum[WIDTH]; sc_sov = ovf;
            end
            F_SLT:  begin
                sc_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
                sc_cout = sum[WIDTH]; sc_uov = ~sum[WIDTH]; sc_sov = ovf;
            end
            F_SLTU: begin
                sc_res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
                sc_cout = sum[WIDTH]; sc_uov = ~sum[WIDTH]; sc_sov = ovf;
            end
            F_AND:  sc_res = opa & opb;
            F_OR:   sc_res = opa | opb;
            F_XOR:  sc_res = opa ^ opb;
            F_NOR:  sc_res = ~(opa | opb);
            default: sc_ill = 1'b1;
        endcase
    end

    // One multiply/divide iteration plus sign fix-up of the final iteration.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
        step    = {mul_sum, acc_q[WIDTH-1:1]};
        prod    = negp_q ? (~step + 1'b1) : step;
        fin_hi  = prod[2*WIDTH-1:WIDTH];
        fin_lo  = prod[WIDTH-1:0];
        fin_sov = 1'b0;
        fin_dz  = 1'b0;
`ifdef ALU_MDU_DIV_EN
        div_r    = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_r - {1'b0, bmag_q};
        div_next = div_diff[WIDTH] ? {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        quo = div_next[WIDTH-1:0];
        rem = div_next[2*WIDTH-1:WIDTH];
        if (div_q) begin
            step    = div_next;
            // a zero divisor leaves the dividend as remainder; only the quotient is forced
            fin_lo  = dzp_q ? '1 : (negp_q ? (~quo + 1'b1) : quo);
            fin_hi  = negr_q ? (~rem + 1'b1) : rem;
            fin_sov = ovp_q;
            fin_dz  = dzp_q;
        end
`endif
    end

    // Sequencer next state and result/flag/HI/LO updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        bmag_d    = bmag_q;
        negp_d    = negp_q;
`ifdef ALU_MDU_DIV_EN
        div_d     = div_q;
        negr_d    = negr_q;
        dzp_d     = dzp_q;
        ovp_d     = ovp_q;
`endif
        res_d     = res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        zero_d    = zero_q;
        cout_d    = cout_q;
        uov_d     = uov_q;
        sov_d     = sov_q;
        dz_d      = dz_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        case (state_q)
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    hi_d      = fin_hi;
                    lo_d      = fin_lo;
                    res_d     = fin_lo;
                    zero_d    = (fin_lo == '0);
                    cout_d    = 1'b0;
                    uov_d     = 1'b0;
                    sov_d     = fin_sov;
                    dz_d      = fin_dz;
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                // DONE behaves like IDLE: busy is low, so a new start is taken
                state_d = IDLE;
                if (start && is_mc) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                    bmag_d  = b_mag;
                    negp_d  = a_neg ^ b_neg;
`ifdef ALU_MDU_DIV_EN
                    div_d   = is_divop;
                    negr_d  = a_neg;
                    dzp_d   = is_divop && (opb == '0);
                    ovp_d   = (func == F_DIV) && (opa == MIN_VAL) && (opb == '1);
`endif
                end else if (start) begin
                    res_d     = sc_res;
                    zero_d    = (sc_res == '0);
                    cout_d    = sc_cout;
                    uov_d     = sc_uov;
                    sov_d     = sc_sov;
                    dz_d      = 1'b0;
                    illegal_d = sc_ill;
                    done_d    = 1'b1;
                    if (sc_wh) hi_d = opa;
                    if (sc_wl) lo_d = opa;
                end
            end
        endcase
    end

    // State and output registers; reset wins over any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            bmag_q    <= '0;
            negp_q    <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            div_q     <= 1'b0;
            negr_q    <= 1'b0;
            dzp_q     <= 1'b0;
            ovp_q     <= 1'b0;
`endif
            res_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            zero_q    <= 1'b1;
            cout_q    <= 1'b0;
            uov_q     <= 1'b0;
            sov_q     <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            bmag_q    <= bmag_d;
            negp_q    <= negp_d;
`ifdef ALU_MDU_DIV_EN
            div_q     <= div_d;
            negr_q    <= negr_d;
            dzp_q     <= dzp_d;
            ovp_q     <= ovp_d;
`endif
            res_q     <= res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            zero_q    <= zero_d;
            cout_q    <= cout_d;
            uov_q     <= uov_d;
            sov_q     <= sov_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign res     = res_q;
    assign zero    = zero_q;
    assign cout    = cout_q;
    assign uov     = uov_q;
    assign sov     = sov_q;
    assign dz      = dz_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign illegal = illegal_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vectors on a 32-bit instance checked every cycle
// against an arithmetic model, plus literal expectations, and a 16-bit
// instance exercised for the division build option.
module tb_alu_mdu;
    localparam logic [5:0] SLL = 6'h00, SRL = 6'h02, SRA = 6'h03;
    localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;
    localparam logic [5:0] ADD = 6'h20, SUB = 6'h22, AND_ = 6'h24, OR_ = 6'h25;
    localparam logic [5:0] XOR_ = 6'h26, NOR_ = 6'h27, SLT = 6'h2A, SLTU = 6'h2B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [5:0]  func;
    logic [31:0] opa, opb, res, hi, lo;
    logic        zero, cout, uov, sov, dz, busy, done, illegal;

    alu_mdu #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(start), .func(func), .opa(opa), .opb(opb),
        .res(res), .zero(zero), .cout(cout), .uov(uov), .sov(sov), .dz(dz),
        .busy(busy), .done(done), .illegal(illegal), .hi(hi), .lo(lo));

    logic        s_start;
    logic [5:0]  s_func;
    logic [15:0] s_opa, s_opb, s_res, s_hi, s_lo;
    logic        s_zero, s_cout, s_uov, s_sov, s_dz, s_busy, s_done, s_illegal;

    alu_mdu #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(s_start), .func(s_func), .opa(s_opa), .opb(s_opb),
        .res(s_res), .zero(s_zero), .cout(s_cout), .uov(s_uov), .sov(s_sov), .dz(s_dz),
        .busy(s_busy), .done(s_done), .illegal(s_illegal), .hi(s_hi), .lo(s_lo));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- arithmetic model of one operation ----------------
    typedef struct {
        logic [31:0] res, hi, lo;
        logic        cout, uov, sov, dz, ill, mc;
    } exp_t;

    function automatic exp_t model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] chi, input logic [31:0] clo);
        exp_t e;
        longint sa, sb, s;
        logic [63:0] p;
        e.res = '0; e.hi = chi; e.lo = clo;
        e.cout = 0; e.uov = 0; e.sov = 0; e.dz = 0; e.ill = 0; e.mc = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            SLL:  e.res = b << a[4:0];
            SRL:  e.res = b >> a[4:0];
            SRA:  e.res = $signed(b) >>> a[4:0];
            MFHI: e.res = chi;
            MFLO: e.res = clo;
            MTHI: begin e.res = a; e.hi = a; end
            MTLO: begin e.res = a; e.lo = a; end
            MULT: begin
                p = 64'(sa * sb);
                e.mc = 1; e.hi = p[63:32]; e.lo = p[31:0]; e.res = p[31:0];
            end
            MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                e.mc = 1; e.hi = p[63:32]; e.lo = p[31:0]; e.res = p[31:0];
            end
`ifdef ALU_MDU_DIV_EN
            DIV: begin
                e.mc = 1;
                if (b == 0) begin e.lo = '1; e.hi = a; e.dz = 1; end
                else begin
                    s = sa / sb; e.lo = s[31:0];
                    s = sa % sb; e.hi = s[31:0];
                    e.sov = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
                end
                e.res = e.lo;
            end
            DIVU: begin
                e.mc = 1;
                if (b == 0) begin e.lo = '1; e.hi = a; e.dz = 1; end
                else begin e.lo = a / b; e.hi = a % b; end
                e.res = e.lo;
            end
`endif
            ADD: begin
                e.res = a + b;
                e.cout = ({32'b0, a} + {32'b0, b}) > 64'hFFFFFFFF;
                e.uov = e.cout;
                s = sa + sb; e.sov = (s != longint'(int'(s)));
            end
            SUB, SLT, SLTU: begin
                e.cout = (a >= b);
                e.uov = (a < b);
                s = sa - sb; e.sov = (s != longint'(int'(s)));
                if (f == SUB) e.res = a - b;
                else if (f == SLT) e.res = (sa < sb) ? 32'd1 : 32'd0;
                else e.res = (a < b) ? 32'd1 : 32'd0;
            end
            AND_: e.res = a & b;
            OR_:  e.res = a | b;
            XOR_: e.res = a ^ b;
            NOR_: e.res = ~(a | b);
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    // ---------------- cycle tracking of the model ----------------
    logic [31:0] m_res, m_hi, m_lo;
    logic        m_zero, m_cout, m_uov, m_sov, m_dz, m_ill, m_busy, m_done;
    int          m_left = 0;
    bit          m_valid = 0;
    exp_t        m_pend;

    task automatic apply(input exp_t e);
        m_res = e.res; m_hi = e.hi; m_lo = e.lo; m_zero = (e.res == 0);
        m_cout = e.cout; m_uov = e.uov; m_sov = e.sov; m_dz = e.dz; m_ill = e.ill;
        m_done = 1;
    endtask

    // Advance the model on each rising edge using the inputs it samples.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_valid = 1; m_left = 0;
            m_res = 0; m_hi = 0; m_lo = 0; m_zero = 1;
            m_cout = 0; m_uov = 0; m_sov = 0; m_dz = 0; m_ill = 0; m_busy = 0; m_done = 0;
        end else if (m_valid) begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) apply(m_pend);
            end else if (start) begin
                e = model_op(func, opa, opb, m_hi, m_lo);
                if (e.mc) begin m_pend = e; m_left = 32; end
                else apply(e);
            end
            m_busy = (m_left > 0);
        end
    end

    // Compare the 32-bit instance with the model every cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_res", res, m_res);
            chk("m_flags{zero,cout,uov,sov,dz,illegal}", {zero, cout, uov, sov, dz, illegal},
                {m_zero, m_cout, m_uov, m_sov, m_dz, m_ill});
            chk("m_busy_done", {busy, done}, {m_busy, m_done});
            chk("m_hi", hi, m_hi);
            chk("m_lo", lo, m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic op32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1; func = f; opa = a; opb = b;
        @(negedge clk);
        start = 0;
    endtask

    task automatic op16(input logic [5:0] f, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        s_start = 1; s_func = f; s_opa = a; s_opb = b;
        @(negedge clk);
        s_start = 0;
    endtask

    // cyc is the cycle (counted from 1 = first cycle after the start edge) where done is seen
    task automatic wait_done32(output int cyc, output int bcyc);
        cyc = 1; bcyc = 0;
        while (!done && cyc < 100) begin
            if (busy) bcyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, bcyc, nd;
        rst = 1; start = 0; func = '0; opa = '0; opb = '0;
        s_start = 0; s_func = '0; s_opa = '0; s_opb = '0;
        repeat (2) @(negedge clk);
        chk("rst_res", res, 0);
        chk("rst_flags{zero,cout,uov,sov,dz,illegal}", {zero, cout, uov, sov, dz, illegal}, 6'b100000);
        chk("rst_ctrl{busy,done}", {busy, done}, 2'b00);
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst16_zero_res", {s_zero, s_res}, {1'b1, 16'h0});
        rst = 0;

        // single-cycle arithmetic and boundaries
        op32(ADD, 32'hFFFFFFFF, 32'h1);
        chk("add_wrap_res", res, 0);
        chk("add_wrap{zero,cout,uov,sov}", {zero, cout, uov, sov}, 4'b1110);
        chk("add_wrap_done", {busy, done}, 2'b01);
        op32(ADD, 32'h7FFFFFFF, 32'h1);
        chk("add_sov_res", res, 32'h80000000);
        chk("add_sov{zero,cout,uov,sov}", {zero, cout, uov, sov}, 4'b0001);
        op32(SUB, 32'h80000000, 32'h1);
        chk("sub_res", res, 32'h7FFFFFFF);
        chk("sub{zero,cout,uov,sov}", {zero, cout, uov, sov}, 4'b0101);
        op32(SLT, 32'h80000000, 32'h1);
        chk("slt_res", res, 32'h1);
        op32(SLTU, 32'h1, 32'h2);
        chk("sltu_res", res, 32'h1);
        op32(SLTU, 32'h2, 32'h1);
        op32(SRA, 32'd4, 32'hF0000000);
        chk("sra_res", res, 32'hFF000000);
        op32(SLL, 32'd36, 32'h1);
        chk("sll_wrap_amt", res, 32'h10);
        op32(SRL, 32'd4, 32'hF0000000);
        chk("srl_res", res, 32'h0F000000);
        op32(AND_, 32'hF0F0F0F0, 32'hFF00FF00);
        op32(OR_, 32'hF0F0F0F0, 32'h0F000000);
        op32(XOR_, 32'hFFFF0000, 32'hF0F0F0F0);
        op32(NOR_, 32'h0, 32'h0);
        chk("nor_res", res, 32'hFFFFFFFF);
        op32(6'h3F, 32'h1, 32'h2);
        chk("illegal_res", {illegal, res}, {1'b1, 32'h0});
        op32(6'h01, 32'h5, 32'h5);

        // HI/LO moves
        op32(MTHI, 32'hDEADBEEF, 32'h0);
        chk("mthi_hi", hi, 32'hDEADBEEF);
        op32(MTLO, 32'h12345678, 32'h0);
        op32(MFHI, 32'h0, 32'h0);
        chk("mfhi_res", res, 32'hDEADBEEF);
        op32(MFLO, 32'h0, 32'h0);
        chk("mflo_res", res, 32'h12345678);
        op32(ADD, 32'h1, 32'h1);
        chk("add_keeps_hilo", {hi, lo}, {32'hDEADBEEF, 32'h12345678});

        // multiply
        op32(MULT, 32'hFFFFFFFF, 32'h2);
        wait_done32(cyc, bcyc);
        chk("mult_done_cycle", cyc, 33);
        chk("mult_busy_cycles", bcyc, 32);
        chk("mult_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFE});
        chk("mult_res", res, 32'hFFFFFFFE);
        op32(MULTU, 32'hFFFFFFFF, 32'h2);
        wait_done32(cyc, bcyc);
        chk("multu_hilo", {hi, lo}, {32'h00000001, 32'hFFFFFFFE});
        op32(MULT, 32'h80000000, 32'h80000000);
        wait_done32(cyc, bcyc);
        chk("mult_min_sq", {hi, lo, zero}, {32'h40000000, 32'h0, 1'b1});
        op32(MULT, 32'd7, 32'hFFFFFFFD);
        wait_done32(cyc, bcyc);
        chk("mult_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});

        // divide
`ifdef ALU_MDU_DIV_EN
        op32(DIV, 32'hFFFFFFF9, 32'd2);
        wait_done32(cyc, bcyc);
        chk("div_done_cycle", cyc, 33);
        chk("div_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        op32(DIVU, 32'd5, 32'd0);
        wait_done32(cyc, bcyc);
        chk("divu_dz", {hi, lo, dz}, {32'd5, 32'hFFFFFFFF, 1'b1});
        op32(DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done32(cyc, bcyc);
        chk("div_ovf", {hi, lo, sov}, {32'h0, 32'h80000000, 1'b1});
        op32(DIV, 32'd7, 32'hFFFFFFFE);
        wait_done32(cyc, bcyc);
        op32(DIV, 32'h80000000, 32'h0);
        wait_done32(cyc, bcyc);
        op32(DIVU, 32'hFFFFFFFF, 32'd10);
        wait_done32(cyc, bcyc);
        chk("divu_big", {hi, lo}, {32'd5, 32'h19999999});
`else
        op32(DIV, 32'hFFFFFFF9, 32'd2);
        chk("div_off_illegal", {illegal, res, busy, done}, {1'b1, 32'h0, 1'b0, 1'b1});
        chk("div_off_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
        op32(DIVU, 32'd5, 32'd0);
`endif

        // start while busy is ignored
        op32(MULT, 32'd3, 32'd5);
        repeat (3) @(negedge clk);
        start = 1; func = ADD; opa = 32'd1; opb = 32'd1;
        @(negedge clk);
        start = 0;
        count_done(40, nd);
        chk("busy_start_one_done", nd, 1);
        chk("busy_start_result", {res, hi, lo}, {32'd15, 32'd0, 32'd15});

        // reset during RUN cycle 10
        op32(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_state", {busy, done, hi, lo}, {2'b00, 64'h0});
        count_done(40, nd);
        chk("abort_no_done", nd, 0);

        // 16-bit instance
        op16(MTHI, 16'h1234, 16'h0);
        op16(MTLO, 16'hABCD, 16'h0);
        op16(ADD, 16'hFFFF, 16'h1);
        chk("add16", {s_res, s_zero, s_cout}, {16'h0, 2'b11});
        op16(DIV, 16'd7, 16'd2);
`ifdef ALU_MDU_DIV_EN
        cyc = 1;
        while (!s_done && cyc < 100) begin @(negedge clk); cyc++; end
        chk("div16_done_cycle", cyc, 17);
        chk("div16_hilo", {s_hi, s_lo}, {16'd1, 16'd3});
`else
        chk("div16_illegal", {s_illegal, s_res, s_busy, s_done}, {1'b1, 16'h0, 1'b0, 1'b1});
        chk("div16_hilo_kept", {s_hi, s_lo}, {16'h1234, 16'hABCD});
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
